// File: rtl/histogram_equalizer_if.sv
// Histogram equalizer bus interface.
// Bundles the operation requests, source/result pixel tables, the histogram
// RAM read port and the status outputs.
//   master : requester side (drives starts, image_table and RAM read data)
//   slave  : equalizer side (drives RAM address, results and status)
interface histogram_equalizer_if #(
  parameter int PIXEL_WIDTH              = 8,
  parameter int TABLE_SIZE               = 64,
  parameter int HISTOGRAM_RAM_DATA_WIDTH = 17
);
  logic                                start_min_search;
  logic                                start_equalize;
  logic [TABLE_SIZE*PIXEL_WIDTH-1:0]   image_table;
  logic [HISTOGRAM_RAM_DATA_WIDTH-1:0] histogram_RAM_data;
  logic [PIXEL_WIDTH-1:0]              histogram_RAM_address;
  logic [TABLE_SIZE*PIXEL_WIDTH-1:0]   equalized_table;
  logic [HISTOGRAM_RAM_DATA_WIDTH-1:0] cdf_min;
  logic                                busy;
  logic                                done;

  modport master (
    output start_min_search, start_equalize, image_table, histogram_RAM_data,
    input  histogram_RAM_address, equalized_table, cdf_min, busy, done
  );

  modport slave (
    input  start_min_search, start_equalize, image_table, histogram_RAM_data,
    output histogram_RAM_address, equalized_table, cdf_min, busy, done
  );
endinterface

// File: rtl/histogram_equalizer.sv
// Histogram equalizer (CDF reader side).
// Scans the finished CDF in the shared histogram RAM for the first non-zero
// value (cdf_min), then remaps an 8x8 pixel table to
//   eq = floor((cdf[p] - cdf_min) * MAXV / (N - cdf_min))
// using a restoring divider, one quotient bit per cycle. Never writes the RAM.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : histogram_equalizer_if.slave (starts, tables, RAM port, status)
//
// state    | meaning
// IDLE     | waiting for a start request, address 0
// MIN_SCAN | walking the CDF from address 0 for the first non-zero word
// EQ_FETCH | reading cdf of pixel i, loading the divider
// EQ_DIV   | restoring division, one quotient bit per cycle, MSB first
// EQ_STORE | writing the quotient into slot i of equalized_table
// DONE     | one-cycle done pulse, back to IDLE
module histogram_equalizer #(
  parameter int IMAGE_WIDTH              = 320,
  parameter int IMAGE_HEIGHT             = 240,
  parameter int PIXEL_WIDTH              = 8,
  parameter int TABLE_SIZE               = 64,
  parameter int HISTOGRAM_RAM_DATA_WIDTH = $clog2(IMAGE_WIDTH*IMAGE_HEIGHT)
) (
  input logic                   clk,
  input logic                   rst,
  histogram_equalizer_if.slave  bus
);

  localparam int DW = HISTOGRAM_RAM_DATA_WIDTH;
  localparam int PW = PIXEL_WIDTH;
  localparam int RW = DW + PW;
  localparam int IW = $clog2(TABLE_SIZE);
  localparam int BW = $clog2(PW);
  localparam logic [DW-1:0] N_PIX = DW'(IMAGE_WIDTH*IMAGE_HEIGHT);
  localparam logic [PW-1:0] MAXV  = '1;

  typedef enum logic [2:0] {
    IDLE, MIN_SCAN, EQ_FETCH, EQ_DIV, EQ_STORE, DONE
  } state_t;

  state_t                     state;
  logic [PW-1:0]              scan_index;
  logic [IW-1:0]              pixel_index;
  logic [RW-1:0]              remainder;
  logic [BW-1:0]              bit_idx;
  logic [PW-1:0]              quot;
  logic [DW-1:0]              cdf_min_r;
  logic [TABLE_SIZE*PW-1:0]   eq_table_r;
  logic                       busy_r;
  logic                       done_r;

  logic [PW-1:0] cur_pixel;
  logic [DW-1:0] den;
  logic [RW-1:0] num;
  logic [RW-1:0] den_shift;
  logic [PW-1:0] address;

  assign cur_pixel = bus.image_table[pixel_index*PW +: PW];
  assign den       = N_PIX - cdf_min_r;
  assign den_shift = RW'(den) << bit_idx;

  // CDF values below cdf_min can only come from empty bins; they map to 0.
  always_comb begin
    num = '0;
    if (bus.histogram_RAM_data > cdf_min_r)
      num = RW'(bus.histogram_RAM_data - cdf_min_r) * RW'(MAXV);
  end

  // The RAM read is asynchronous, so the address follows the current state
  // and index directly; data for it is sampled on the next edge.
  always_comb begin
    address = '0;
    case (state)
      MIN_SCAN: address = scan_index;
      EQ_FETCH: address = cur_pixel;
      default:  address = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      scan_index  <= '0;
      pixel_index <= '0;
      remainder   <= '0;
      bit_idx     <= '0;
      quot        <= '0;
      cdf_min_r   <= '0;
      eq_table_r  <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          // Min search has priority; a simultaneous equalize request is dropped.
          if (bus.start_min_search) begin
            state      <= MIN_SCAN;
            scan_index <= '0;
            busy_r     <= 1'b1;
          end else if (bus.start_equalize) begin
            state       <= EQ_FETCH;
            pixel_index <= '0;
            busy_r      <= 1'b1;
          end
        end
        MIN_SCAN: begin
          if (bus.histogram_RAM_data != '0) begin
            cdf_min_r <= bus.histogram_RAM_data;
            state     <= DONE;
            done_r    <= 1'b1;
          end else if (scan_index == MAXV) begin
            cdf_min_r <= '0;
            state     <= DONE;
            done_r    <= 1'b1;
          end else begin
            scan_index <= scan_index + 1'b1;
          end
        end
        EQ_FETCH: begin
          // A flat image leaves no dynamic range; pass pixels through.
          if (den == '0) begin
            quot  <= cur_pixel;
            state <= EQ_STORE;
          end else begin
            remainder <= num;
            bit_idx   <= BW'(PW-1);
            quot      <= '0;
            state     <= EQ_DIV;
          end
        end
        EQ_DIV: begin
          if (remainder >= den_shift) begin
            remainder     <= remainder - den_shift;
            quot[bit_idx] <= 1'b1;
          end else begin
            quot[bit_idx] <= 1'b0;
          end
          if (bit_idx == '0)
            state <= EQ_STORE;
          else
            bit_idx <= bit_idx - 1'b1;
        end
        EQ_STORE: begin
          eq_table_r[pixel_index*PW +: PW] <= quot;
          if (pixel_index == IW'(TABLE_SIZE-1)) begin
            state  <= DONE;
            done_r <= 1'b1;
          end else begin
            pixel_index <= pixel_index + 1'b1;
            state       <= EQ_FETCH;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_r <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.histogram_RAM_address = address;
  assign bus.equalized_table       = eq_table_r;
  assign bus.cdf_min               = cdf_min_r;
  assign bus.busy                  = busy_r;
  assign bus.done                  = done_r;

endmodule
